// File: rtl/audio_mixer_n.sv
// N-channel gain/fade audio mixer: sequential multiply-accumulate over the
// channels, a fade-level scale, then saturation to the output width.
module audio_mixer_n #(
    parameter int NCH       = 4,
    parameter int IN_W      = 16,
    parameter int GAIN_W    = 8,
    parameter int OUT_W     = 16,
    parameter int FADE_W    = 8,
    parameter int RAMP_STEP = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_en,
    input  logic                     ramp_en,
    input  logic                     enable,
    input  logic [NCH*IN_W-1:0]      ch_in,
    input  logic [NCH*GAIN_W-1:0]    ch_gain,
    output logic signed [OUT_W-1:0]  out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     clip,
    output logic                     overrun
);

    localparam int ACC_W = IN_W + GAIN_W + $clog2(NCH) + 1;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LVL_W = FADE_W + 1;
    localparam int SCL_W = ((ACC_W + LVL_W + 1) > (OUT_W + 1)) ? (ACC_W + LVL_W + 1) : (OUT_W + 1);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NCH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = {1'b1, {FADE_W{1'b0}}};
    localparam logic [LVL_W-1:0] LVL_STEP  = LVL_W'(RAMP_STEP);
    localparam logic signed [SCL_W-1:0] SAT_MAX = {{(SCL_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SCL_W-1:0] SAT_MIN = {{(SCL_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, EMIT} state_t;

    state_t                     r_state;
    logic [NCH*IN_W-1:0]        r_ch;
    logic [NCH*GAIN_W-1:0]      r_gain;
    logic [LVL_W-1:0]           r_level;
    logic [LVL_W-1:0]           r_lvl_snap;
    logic signed [ACC_W-1:0]    r_acc;
    logic [IDX_W-1:0]           r_idx;
    logic signed [SCL_W-1:0]    r_scaled;
    logic signed [OUT_W-1:0]    r_out;
    logic                       r_valid;
    logic                       r_busy;
    logic                       r_clip;
    logic                       r_overrun;

    logic signed [IN_W-1:0]     w_ch_cur;
    logic signed [GAIN_W:0]     w_gain_cur;
    logic signed [ACC_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [SCL_W-1:0]    w_scl;
    logic [LVL_W:0]             w_up_sum;
    logic [LVL_W-1:0]           w_level_next;
    logic signed [OUT_W-1:0]    w_sat_out;
    logic                       w_sat_clip;

    // Snapshot registers shift down one channel per ACCUM cycle, so the
    // current channel always sits in the low slice.
    assign w_ch_cur   = $signed(r_ch[IN_W-1:0]);
    assign w_gain_cur = $signed({1'b0, r_gain[GAIN_W-1:0]});
    assign w_prod     = ACC_W'(w_ch_cur) * ACC_W'(w_gain_cur);
    assign w_term     = w_prod >>> (GAIN_W - 1);
    assign w_scl      = (SCL_W'(r_acc) * SCL_W'($signed({1'b0, r_lvl_snap}))) >>> FADE_W;
    assign w_up_sum   = {1'b0, r_level} + {1'b0, LVL_STEP};

    always_comb begin
        w_level_next = r_level;
        if (enable) begin
            if (w_up_sum >= {1'b0, LVL_FULL}) w_level_next = LVL_FULL;
            else                              w_level_next = w_up_sum[LVL_W-1:0];
        end else begin
            if (r_level <= LVL_STEP) w_level_next = '0;
            else                     w_level_next = r_level - LVL_STEP;
        end
    end

    always_comb begin
        w_sat_out  = r_scaled[OUT_W-1:0];
        w_sat_clip = 1'b0;
        if (r_scaled > SAT_MAX) begin
            w_sat_out  = SAT_MAX[OUT_W-1:0];
            w_sat_clip = 1'b1;
        end else if (r_scaled < SAT_MIN) begin
            w_sat_out  = SAT_MIN[OUT_W-1:0];
            w_sat_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ch       <= '0;
            r_gain     <= '0;
            r_level    <= '0;
            r_lvl_snap <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_scaled   <= '0;
            r_out      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_clip     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (ramp_en)
                r_level <= w_level_next;
            if (sample_en && (r_state != IDLE))
                r_overrun <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (sample_en) begin
                        r_ch       <= ch_in;
                        r_gain     <= ch_gain;
                        r_lvl_snap <= r_level;
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_acc  <= r_acc + w_term;
                    r_ch   <= r_ch >> IN_W;
                    r_gain <= r_gain >> GAIN_W;
                    if (r_idx == IDX_LAST) r_state <= SCALE;
                    else                   r_idx   <= r_idx + IDX_W'(1);
                end
                SCALE: begin
                    r_scaled <= w_scl;
                    r_state  <= EMIT;
                end
                EMIT: begin
                    r_out   <= w_sat_out;
                    r_clip  <= w_sat_clip;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign clip      = r_clip;
    assign overrun   = r_overrun;

endmodule

// File: doc/audio_mixer_n.md
AUDIO_MIXER_N -- requirements
Module: audio_mixer_n

Interface
REQ-001 SHALL have parameter NCH, default 4: number of mixed channels, 1..16.
REQ-002 SHALL have parameter IN_W, default 16: signed channel sample width.
REQ-003 SHALL have parameter GAIN_W, default 8: unsigned per-channel gain width; unity gain = 2^(GAIN_W-1).
REQ-004 SHALL have parameter OUT_W, default 16: signed output width.
REQ-005 SHALL have parameter FADE_W, default 8: fade level fraction bits; full level = 2^FADE_W.
REQ-006 SHALL have parameter RAMP_STEP, default 16: fade level change per ramp tick.
REQ-007 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port sample_en, input, 1: one-clk strobe that starts a mix.
REQ-010 SHALL have port ramp_en, input, 1: one-clk fade step tick.
REQ-011 SHALL have port enable, input, 1: 1 fades up to full level, 0 fades down to silence.
REQ-012 SHALL have port ch_in, input, NCH*IN_W: signed samples, channel 0 in the LSBs.
REQ-013 SHALL have port ch_gain, input, NCH*GAIN_W: unsigned gains, channel 0 in the LSBs.
REQ-014 SHALL have port out, output, OUT_W: signed mixed sample, registered.
REQ-015 SHALL have port out_valid, output, 1: one-clk pulse when out updates.
REQ-016 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-017 SHALL have port clip, output, 1: set with out_valid if that sample saturated, else cleared with out_valid.
REQ-018 SHALL have port overrun, output, 1: sticky; cleared only by reset.

Function
REQ-019 SHALL implement the states IDLE, ACCUM, SCALE and EMIT.
REQ-020 In IDLE with sample_en=1, SHALL snapshot ch_in, ch_gain and the fade level, clear the accumulator and channel index, and enter ACCUM.
REQ-021 ACCUM SHALL add the product ch[i]*gain[i], arithmetically shifted right by GAIN_W-1, to the accumulator, processing one channel per clk for i = 0..NCH-1.
REQ-022 ACCUM SHALL enter SCALE after channel NCH-1.
REQ-023 The accumulator SHALL be IN_W+GAIN_W+clog2(NCH)+1 bits wide and SHALL never overflow internally.
REQ-024 SCALE SHALL multiply the accumulator by the snapshotted level, arithmetically shift right by FADE_W, then enter EMIT.
REQ-025 EMIT SHALL saturate the scaled value to [-2^(OUT_W-1), 2^(OUT_W-1)-1], register it on out, pulse out_valid, update clip, and return to IDLE.
REQ-026 Latency SHALL be exact: out and out_valid update on the clk edge NCH+2 edges after the edge that sampled sample_en.
REQ-027 Back-to-back mixes SHALL be possible every NCH+3 clks.
REQ-028 A sample_en while busy=1 SHALL be ignored, SHALL set overrun, and SHALL NOT disturb the mix in flight.
REQ-029 Inputs changing during a mix SHALL NOT affect that mix's result.
REQ-030 The fade level SHALL reset to 0.
REQ-031 On ramp_en with enable=1, the fade level SHALL increase by RAMP_STEP, clamped at 2^FADE_W.
REQ-032 On ramp_en with enable=0, the fade level SHALL decrease by RAMP_STEP, clamped at 0.
REQ-033 The fade level SHALL be unchanged when ramp_en=0.
REQ-034 When ramp_en and sample_en occur in the same clk, the snapshot SHALL take the pre-update level.
REQ-035 out SHALL hold its value between out_valid pulses.

Reset
REQ-036 rst_n=0 SHALL immediately and asynchronously force state=IDLE, out=0, out_valid=0, busy=0, clip=0, overrun=0, fade level=0, accumulator=0 and index=0.
REQ-037 Reset asserted mid-mix SHALL abort the mix with no out_valid pulse.
REQ-038 Release of rst_n SHALL be synchronous to clk; the first sample_en is accepted on the first edge after release.

Verification (defaults; level first ramped to 256 with 16 ramp_en pulses at enable=1)
REQ-039 Reset then idle -> out=0, out_valid=0, busy=0, clip=0, overrun=0, and a mix at level 0 yields out=0.
REQ-040 ch={1000,2000,-500,0}, gains all 128, sample_en -> out=2500 and clip=0 exactly 6 edges later, with busy high for the intervening cycles.
REQ-041 All ch=30000, gains 255 -> out=32767, clip=1; all ch=-30000, gains 255 -> out=-32768, clip=1.
REQ-042 ch={8000,0,0,0}, gain 128, then enable=0 with 8 ramp_en pulses (level 128) -> out=4000; after 8 more pulses -> out=0, and further pulses keep level at 0.
REQ-043 sample_en repeated 2 clks after a start -> overrun=1, first result unchanged (2500 for the REQ-040 stimulus), and only one out_valid pulse.
REQ-044 rst_n low 3 clks into a mix -> no out_valid pulse, all outputs 0, and a new mix after release is correct.
